imem_stream_loader: RTL and testbench

- Upstream feeder for the KGP-RISC MIPS core. Receives a byte stream (program image) over a valid/ready handshake and assembles big-endian 32-bit instruction words.
- Writes each word into the instruction memory write port at consecutive word addresses.
- Holds the core in reset until the image is fully loaded and its checksum verifies. This replaces the simulation-only memory preload with a synthesizable boot path.

---
 rtl/imem_stream_loader.sv | 132 +++++++++++++
 tb/tb_imem_stream_loader.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_stream_loader.sv
// Boot-time loader: assembles big-endian words from a byte stream, writes them to
// instruction memory and releases the core only after the image checksum verifies.
module imem_stream_loader #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset,
    output logic              load_done,
    output logic              load_error,
    output logic [ADDR_W:0]   words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CHK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t      state;
    logic [1:0]  byte_idx;
    logic [23:0] word_acc;
    logic [7:0]  sum_acc;
    logic [15:0] word_count;
    logic        take;

    assign take = in_valid && in_ready;

    // NOTE: all state and outputs update with non-blocking assignments so every
    // branch below sees the pre-edge values, regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            byte_idx     <= '0;
            word_acc     <= '0;
            sum_acc      <= '0;
            word_count   <= '0;
            in_ready     <= 1'b0;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            cpu_reset    <= 1'b1;
            load_done    <= 1'b0;
            load_error   <= 1'b0;
            words_loaded <= '0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (load_start) begin
                        state        <= S_LEN_HI;
                        byte_idx     <= '0;
                        sum_acc      <= '0;
                        words_loaded <= '0;
                        in_ready     <= 1'b1;
                        cpu_reset    <= 1'b1;
                        load_done    <= 1'b0;
                        load_error   <= 1'b0;
                    end
                end
                S_LEN_HI: begin
                    if (take) begin
                        word_count[15:8] <= in_data;
                        state            <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (take) begin
                        word_count[7:0] <= in_data;
                        if ({word_count[15:8], in_data} > 16'(DEPTH)) begin
                            state      <= S_ERROR;
                            in_ready   <= 1'b0;
                            load_error <= 1'b1;
                        end else if ({word_count[15:8], in_data} == 16'd0) begin
                            state <= S_CHK;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (take) begin
                        sum_acc  <= sum_acc + in_data;
                        byte_idx <= byte_idx + 2'd1;
                        word_acc <= {word_acc[15:0], in_data};
                        // The write lands on the cycle after the fourth byte; leaving
                        // DATA at the same edge lets the checksum byte overlap it.
                        if (byte_idx == 2'd3) begin
                            imem_we      <= 1'b1;
                            imem_addr    <= words_loaded[ADDR_W-1:0];
                            imem_wdata   <= {word_acc, in_data};
                            words_loaded <= words_loaded + (ADDR_W+1)'(1);
                            if (16'(words_loaded) + 16'd1 == word_count) begin
                                state <= S_CHK;
                            end
                        end
                    end
                end
                S_CHK: begin
                    if (take) begin
                        in_ready <= 1'b0;
                        if (8'(sum_acc + in_data) == 8'd0) begin
                            state     <= S_DONE;
                            cpu_reset <= 1'b0;
                            load_done <= 1'b1;
                        end else begin
                            state      <= S_ERROR;
                            load_error <= 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_stream_loader.sv
// Self-checking bench for imem_stream_loader: directed frames from the test plan
// plus randomized frames compared against a frame-level reference model.
module tb_imem_stream_loader;

    localparam int DEPTH  = 32;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic              load_start;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_reset;
    logic              load_done;
    logic              load_error;
    logic [ADDR_W:0]   words_loaded;

    imem_stream_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .load_start   (load_start),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_reset    (cpu_reset),
        .load_done    (load_done),
        .load_error   (load_error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int stall_cnt;

    logic [ADDR_W-1:0] wr_addr_q[$];
    logic [31:0]       wr_data_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wr_addr_q.push_back(imem_addr);
            wr_data_q.push_back(imem_wdata);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one byte after an idle gap and returns 1 ns after the edge that took it.
    task automatic send_byte(input logic [7:0] b, input int gap, input bit glitch);
        int waited = 0;
        in_valid = 1'b0;
        repeat (gap) begin
            if (in_ready !== 1'b1) stall_cnt++;
            load_start = glitch && ($urandom_range(0, 5) == 0);
            tick();
            load_start = 1'b0;
        end
        in_data  = b;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && waited < 20) begin
            stall_cnt++;
            waited++;
            tick();
        end
        if (in_ready !== 1'b1) check("accept_timeout", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic run_frame(input string name, input int n, input logic [7:0] data[$],
                             input logic [7:0] chk, input int min_gap, input int max_gap,
                             input bit glitch);
        logic [15:0] len = 16'(n);
        logic [7:0]  sum = 8'd0;
        bit          exp_done;
        int          exp_words;
        logic [31:0] exp_word;

        // Reference: oversize frames stop after the length; others write all N words
        // and succeed when data bytes plus checksum sum to zero modulo 256.
        foreach (data[i]) sum += data[i];
        exp_words = (n > DEPTH) ? 0 : n;
        exp_done  = (n <= DEPTH) && (8'(sum + chk) == 8'd0);

        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        check({name, ".start_cpu_reset"}, 32'(cpu_reset), 32'd1);
        check({name, ".start_done"}, 32'(load_done), 32'd0);
        check({name, ".start_error"}, 32'(load_error), 32'd0);
        check({name, ".start_ready"}, 32'(in_ready), 32'd1);
        check({name, ".start_words"}, 32'(words_loaded), 32'd0);

        wr_addr_q.delete();
        wr_data_q.delete();
        stall_cnt = 0;

        send_byte(len[15:8], $urandom_range(min_gap, max_gap), glitch);
        send_byte(len[7:0], $urandom_range(min_gap, max_gap), glitch);
        if (n <= DEPTH) begin
            foreach (data[i]) send_byte(data[i], $urandom_range(min_gap, max_gap), glitch);
            check({name, ".pre_chk_cpu_reset"}, 32'(cpu_reset), 32'd1);
            send_byte(chk, $urandom_range(min_gap, max_gap), glitch);
        end

        check({name, ".done"}, 32'(load_done), 32'(exp_done));
        check({name, ".error"}, 32'(load_error), 32'(!exp_done));
        check({name, ".cpu_reset"}, 32'(cpu_reset), 32'(!exp_done));
        check({name, ".end_ready"}, 32'(in_ready), 32'd0);
        check({name, ".words_loaded"}, 32'(words_loaded), 32'(exp_words));
        check({name, ".stalls"}, 32'(stall_cnt), 32'd0);

        repeat (2) tick();
        check({name, ".write_count"}, 32'(wr_addr_q.size()), 32'(exp_words));
        for (int w = 0; w < exp_words && w < wr_addr_q.size(); w++) begin
            exp_word = {data[4*w], data[4*w+1], data[4*w+2], data[4*w+3]};
            check($sformatf("%s.addr%0d", name, w), 32'(wr_addr_q[w]), 32'(w));
            check($sformatf("%s.data%0d", name, w), wr_data_q[w], exp_word);
        end
    endtask

    task automatic check_reset_values(input string name);
        check({name, ".in_ready"}, 32'(in_ready), 32'd0);
        check({name, ".imem_we"}, 32'(imem_we), 32'd0);
        check({name, ".imem_addr"}, 32'(imem_addr), 32'd0);
        check({name, ".imem_wdata"}, imem_wdata, 32'd0);
        check({name, ".cpu_reset"}, 32'(cpu_reset), 32'd1);
        check({name, ".load_done"}, 32'(load_done), 32'd0);
        check({name, ".load_error"}, 32'(load_error), 32'd0);
        check({name, ".words_loaded"}, 32'(words_loaded), 32'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] normal[$];
        logic [7:0] empty[$];
        logic [7:0] rnd[$];
        logic [7:0] s;
        logic [7:0] c;
        int         n;
        int         r;

        normal = '{8'h20, 8'h01, 8'h00, 8'h05, 8'h20, 8'h02, 8'h00, 8'h0A};
        empty  = {};

        reset      = 1'b1;
        load_start = 1'b0;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        repeat (3) tick();
        check_reset_values("por");
        reset = 1'b0;
        tick();

        run_frame("normal", 2, normal, 8'hAE, 0, 0, 1'b0);
        run_frame("bad_chk", 2, normal, 8'hAF, 0, 0, 1'b0);
        run_frame("oversize", DEPTH + 1, empty, 8'h00, 0, 0, 1'b0);
        run_frame("zero_len", 0, empty, 8'h00, 0, 0, 1'b0);
        run_frame("throttled", 2, normal, 8'hAE, 3, 3, 1'b0);

        // Abort a load after six data bytes; the partial second word must never land.
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h02, 0, 1'b0);
        for (int i = 0; i < 6; i++) send_byte(normal[i], 0, 1'b0);
        reset = 1'b1;
        tick();
        check_reset_values("mid_reset");
        reset = 1'b0;
        wr_addr_q.delete();
        wr_data_q.delete();
        repeat (4) tick();
        check("mid_reset.no_write", 32'(wr_addr_q.size()), 32'd0);
        run_frame("after_reset", 2, normal, 8'hAE, 0, 0, 1'b0);

        for (int f = 0; f < 14; f++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      n = 0;
            else if (r == 1) n = DEPTH;
            else if (r == 2) n = DEPTH + 1 + $urandom_range(0, 400);
            else             n = $urandom_range(1, 8);
            rnd = {};
            s   = 8'd0;
            if (n <= DEPTH) begin
                for (int i = 0; i < 4 * n; i++) begin
                    rnd.push_back(8'($urandom));
                    s += rnd[i];
                end
            end
            c = ($urandom_range(0, 3) != 0) ? 8'(8'd0 - s) : 8'($urandom);
            run_frame($sformatf("rnd%0d", f), n, rnd, c, 0, 2, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

endmodule
